// File: rtl/imem_line_responder.sv
`timescale 1ns/1ps
// imem_line_responder
// Memory-side responder for the icache refill port. Accepts one line request,
// waits READ_LATENCY cycles (counted from the request cycle), then streams the
// line one word per cycle. A word-write load port initialises the program image.
module imem_line_responder #(
  parameter int MEM_BYTES    = 65536,
  parameter int LINE_SIZE    = 32,
  parameter int READ_LATENCY = 2,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  mem_req_valid_i,
  input  logic [ADDR_WIDTH-1:0] mem_req_addr_i,
  output logic                  mem_req_ready_o,
  output logic                  mem_rsp_valid_o,
  output logic [31:0]           mem_rsp_data_o,
  output logic                  mem_rsp_last_o,
  output logic                  mem_rsp_err_o,
  input  logic                  load_we_i,
  input  logic [ADDR_WIDTH-1:0] load_addr_i,
  input  logic [31:0]           load_data_i,
  output logic                  busy_o,
  output logic [31:0]           req_count_o
);

  localparam int DEPTH  = MEM_BYTES / 4;
  localparam int WPL    = LINE_SIZE / 4;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int BEAT_W = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int CNT_W  = $clog2(READ_LATENCY + 1);

  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(WPL - 1);
  localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(MEM_BYTES);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_SIZE - 1);
  localparam logic [CNT_W-1:0]      CNT_INIT  = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] base, base_next;
  logic                  err, err_next;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic [BEAT_W-1:0]     beat, beat_next;
  logic [31:0]           req_count, req_count_next;
  logic                  rsp_valid, rsp_last, rsp_err;

  logic [31:0]           mem [DEPTH];
  logic [31:0]           rd_data;
  logic [IDX_W-1:0]      rd_idx;
  logic [IDX_W-1:0]      wr_idx;
  logic                  wr_en;

  // Next-state logic: request capture, latency countdown, beat stepping.
  // The counter reaching 1 means the following cycle is READ_LATENCY cycles
  // after the request cycle, so that is where the burst starts.
  always_comb begin
    state_next     = state;
    base_next      = base;
    err_next       = err;
    cnt_next       = cnt;
    beat_next      = beat;
    req_count_next = req_count;
    case (state)
      IDLE: begin
        if (mem_req_valid_i) begin
          base_next      = mem_req_addr_i & LINE_MASK;
          err_next       = (base_next >= MEM_LIMIT);
          cnt_next       = CNT_INIT;
          beat_next      = '0;
          req_count_next = req_count + 32'd1;
          state_next     = (READ_LATENCY == 1) ? BURST : WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_next = BURST;
        end
      end
      BURST: begin
        if (beat == LAST_BEAT) begin
          state_next = IDLE;
        end else begin
          beat_next = beat + BEAT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Read address of the beat presented in the next cycle; the RAM read is
  // registered so the word lines up with its beat.
  always_comb begin
    rd_idx = base_next[IDX_W+1:2] + IDX_W'(beat_next);
    wr_idx = load_addr_i[IDX_W+1:2];
    wr_en  = load_we_i && (load_addr_i < MEM_LIMIT);
  end

  // Control state and registered response flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      base      <= '0;
      err       <= 1'b0;
      cnt       <= '0;
      beat      <= '0;
      req_count <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_next;
      base      <= base_next;
      err       <= err_next;
      cnt       <= cnt_next;
      beat      <= beat_next;
      req_count <= req_count_next;
      rsp_valid <= (state_next == BURST);
      rsp_last  <= (state_next == BURST) && (beat_next == LAST_BEAT);
      rsp_err   <= (state_next == BURST) && err_next;
    end
  end

  // Backing store: write port plus registered read (read-old on collision).
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_idx] <= load_data_i;
    end
    rd_data <= mem[rd_idx];
  end

  // Data is forced to zero outside beats and for out-of-range lines.
  always_comb begin
    mem_rsp_data_o  = (rsp_valid && !rsp_err) ? rd_data : 32'h0;
    mem_rsp_valid_o = rsp_valid;
    mem_rsp_last_o  = rsp_last;
    mem_rsp_err_o   = rsp_err;
    mem_req_ready_o = (state == IDLE);
    busy_o          = (state != IDLE);
    req_count_o     = req_count;
  end

endmodule

// File: tb/tb_imem_line_responder.sv
`timescale 1ns/1ps
// Testbench for imem_line_responder: table vectors, hand-written corner
// sequences and a randomized run checked against a line/array reference model.
module tb_imem_line_responder;

  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready, rsp_valid, rsp_last, rsp_err, busy;
  logic [31:0] rsp_data, req_count;
  logic        load_we;
  logic [31:0] load_addr, load_data;

  logic        lreq_valid;
  logic [31:0] lreq_addr;
  logic        l1_ready, l1_valid, l1_last, l1_err, l1_busy;
  logic [31:0] l1_data, l1_count;
  logic        l5_ready, l5_valid, l5_last, l5_err, l5_busy;
  logic [31:0] l5_data, l5_count;

  always #5 clk = ~clk;

  imem_line_responder dut (
    .clk_i(clk), .rst_ni(rst_n),
    .mem_req_valid_i(req_valid), .mem_req_addr_i(req_addr), .mem_req_ready_o(req_ready),
    .mem_rsp_valid_o(rsp_valid), .mem_rsp_data_o(rsp_data), .mem_rsp_last_o(rsp_last),
    .mem_rsp_err_o(rsp_err), .load_we_i(load_we), .load_addr_i(load_addr),
    .load_data_i(load_data), .busy_o(busy), .req_count_o(req_count)
  );

  imem_line_responder #(.READ_LATENCY(1)) dut_l1 (
    .clk_i(clk), .rst_ni(rst_n),
    .mem_req_valid_i(lreq_valid), .mem_req_addr_i(lreq_addr), .mem_req_ready_o(l1_ready),
    .mem_rsp_valid_o(l1_valid), .mem_rsp_data_o(l1_data), .mem_rsp_last_o(l1_last),
    .mem_rsp_err_o(l1_err), .load_we_i(load_we), .load_addr_i(load_addr),
    .load_data_i(load_data), .busy_o(l1_busy), .req_count_o(l1_count)
  );

  imem_line_responder #(.READ_LATENCY(5)) dut_l5 (
    .clk_i(clk), .rst_ni(rst_n),
    .mem_req_valid_i(lreq_valid), .mem_req_addr_i(lreq_addr), .mem_req_ready_o(l5_ready),
    .mem_rsp_valid_o(l5_valid), .mem_rsp_data_o(l5_data), .mem_rsp_last_o(l5_last),
    .mem_rsp_err_o(l5_err), .load_we_i(load_we), .load_addr_i(load_addr),
    .load_data_i(load_data), .busy_o(l5_busy), .req_count_o(l5_count)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          model_count = 0;
  logic [31:0] model_mem [16384];
  logic [31:0] beat_data [8];
  logic        last_err;

  typedef struct {
    logic [31:0] addr;
    logic        err;
    logic [31:0] b0;
    logic [31:0] b7;
  } vec_t;
  vec_t vt [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Mirror a load that the DUT has just taken at the last edge.
  task automatic apply_load();
    if (load_we && load_addr < 32'h0001_0000) model_mem[load_addr[15:2]] = load_data;
    load_we = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    tick();
    apply_load();
  endtask

  task automatic rand_load(input logic [31:0] base);
    int sel;
    sel = int'($urandom_range(0, 3));
    load_we = 1'b1;
    load_data = $urandom;
    if (sel <= 1)      load_addr = base + 32'($urandom_range(0, 7)) * 32'd4;
    else if (sel == 2) load_addr = 32'($urandom_range(0, 65535));
    else               load_addr = $urandom | 32'h0001_0000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    model_count = 0;
    tick();
  endtask

  // One full line fill on the main DUT. coll_k forces a load that lands on the
  // same edge as beat coll_k's read; rst_k resets the DUT while beat rst_k shows.
  task automatic run_req(input logic [31:0] addr, input bit rnd, input int coll_k,
                         input logic [31:0] coll_addr, input logic [31:0] coll_data,
                         input int rst_k);
    logic [31:0] base;
    logic        err;
    logic [31:0] exp_d;
    int          widx;
    base = addr & 32'hFFFF_FFE0;
    err  = (base >= 32'h0001_0000);
    last_err = err;
    chk("ready_before_req", req_ready, 1);
    req_valid = 1'b1; req_addr = addr;
    tick();
    req_valid = 1'b0; req_addr = $urandom;
    model_count++;
    chk("ready_after_accept", req_ready, 0);
    chk("busy_after_accept", busy, 1);
    chk("req_count", req_count, model_count);
    chk("valid_during_wait", rsp_valid, 0);
    for (int k = 0; k < 8; k++) begin
      widx  = int'(base[15:2]) + k;
      exp_d = err ? 32'h0 : model_mem[widx];
      if (k == coll_k) begin
        load_we = 1'b1; load_addr = coll_addr; load_data = coll_data;
      end else if (rnd && $urandom_range(0, 1) == 1) begin
        rand_load(base);
      end
      tick();
      apply_load();
      chk("beat_valid", rsp_valid, 1);
      chk("beat_data", rsp_data, exp_d);
      chk("beat_err", rsp_err, err);
      chk("beat_last", rsp_last, (k == 7));
      chk("ready_in_burst", req_ready, 0);
      beat_data[k] = rsp_data;
      if (k == rst_k) begin
        rst_n = 1'b0;
        #1;
        model_count = 0;
        chk("rst_valid", rsp_valid, 0);
        chk("rst_last", rsp_last, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", rsp_data, 0);
        chk("rst_count", req_count, 0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", req_ready, 1);
        chk("valid_after_rst", rsp_valid, 0);
        $display("req addr=0x%08h reset during beat %0d", addr, k);
        return;
      end
    end
    tick();
    chk("valid_after_burst", rsp_valid, 0);
    chk("last_after_burst", rsp_last, 0);
    chk("ready_after_burst", req_ready, 1);
    chk("busy_after_burst", busy, 0);
    $display("req addr=0x%08h err=%0d beat0=0x%08h beat7=0x%08h count=%0d",
             addr, err, beat_data[0], beat_data[7], req_count);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, f1, f5, n1, n5, acc, nb, pre;
    logic r;
    logic [31:0] addr;

    vt[0] = '{32'h0000_1004, 1'b0, 32'hA0, 32'hA7};
    vt[1] = '{32'h0000_101C, 1'b0, 32'hA0, 32'hA7};
    vt[2] = '{32'h0001_0000, 1'b1, 32'h0,  32'h0};
    vt[3] = '{32'hFFFF_FFE8, 1'b1, 32'h0,  32'h0};
    vt[4] = '{32'h0000_FFE0, 1'b0, 32'hF0, 32'hF7};
    vt[5] = '{32'h0000_FFFF, 1'b0, 32'hF0, 32'hF7};

    rst_n = 1'b0; req_valid = 1'b0; req_addr = 32'h0;
    load_we = 1'b0; load_addr = 32'h0; load_data = 32'h0;
    lreq_valid = 1'b0; lreq_addr = 32'h0;
    tick();
    tick();
    chk("reset_ready", req_ready, 1);
    chk("reset_valid", rsp_valid, 0);
    chk("reset_last", rsp_last, 0);
    chk("reset_err", rsp_err, 0);
    chk("reset_busy", busy, 0);
    chk("reset_data", rsp_data, 0);
    chk("reset_count", req_count, 0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_release", req_ready, 1);

    // Program image: random everywhere, then known lines.
    for (int i = 0; i < 16384; i++) begin
      load_we = 1'b1; load_addr = 32'(i) * 32'd4; load_data = $urandom;
      tick();
      apply_load();
    end
    for (int k = 0; k < 8; k++) begin
      load_word(32'h1000 + 32'(k) * 4, 32'hA0 + 32'(k));
      load_word(32'hFFE0 + 32'(k) * 4, 32'hF0 + 32'(k));
      load_word(32'h2000 + 32'(k) * 4, 32'hC0 + 32'(k));
    end
    load_word(32'h0001_1000, 32'hBAD0_BAD0);

    // Table vectors: basic fill, out-of-range, top line, later in-range.
    for (int i = 0; i < 6; i++) begin
      run_req(vt[i].addr, 1'b0, -1, 32'h0, 32'h0, -1);
      chk("tbl_err", last_err, vt[i].err);
      chk("tbl_beat0", beat_data[0], vt[i].b0);
      chk("tbl_beat7", beat_data[7], vt[i].b7);
    end

    // Latency sweep on the READ_LATENCY=1 and =5 instances.
    lreq_addr = 32'h40; lreq_valid = 1'b1;
    chk("l1_ready", l1_ready, 1);
    chk("l5_ready", l5_ready, 1);
    t0 = cyc;
    tick();
    lreq_valid = 1'b0;
    f1 = -1; f5 = -1; n1 = 0; n5 = 0;
    for (int i = 0; i < 20; i++) begin
      if (l1_valid) begin
        if (f1 < 0) f1 = cyc;
        chk("l1_data", l1_data, model_mem[16 + (n1 & 7)]);
        chk("l1_last", l1_last, (n1 == 7));
        chk("l1_err", l1_err, 0);
        n1++;
      end
      if (l5_valid) begin
        if (f5 < 0) f5 = cyc;
        chk("l5_data", l5_data, model_mem[16 + (n5 & 7)]);
        chk("l5_last", l5_last, (n5 == 7));
        chk("l5_err", l5_err, 0);
        n5++;
      end
      tick();
    end
    chk("l1_first_beat_cycle", f1, t0 + 1);
    chk("l5_first_beat_cycle", f5, t0 + 5);
    chk("l1_beat_count", n1, 8);
    chk("l5_beat_count", n5, 8);
    chk("l1_req_count", l1_count, 1);
    chk("l5_req_count", l5_count, 1);
    chk("l1_idle", l1_busy, 0);
    chk("l5_idle", l5_busy, 0);
    $display("latency sweep: RL1 first=%0d RL5 first=%0d (request cycle %0d)", f1, f5, t0);

    // Load collisions on line 0x2000.
    run_req(32'h2000, 1'b0, 3, 32'h2008, 32'hDEAD_BEEF, -1);
    chk("coll_old_beat2", beat_data[2], 32'hC2);
    run_req(32'h2000, 1'b0, 4, 32'h2010, 32'h1234_5678, -1);
    chk("coll_new_beat2", beat_data[2], 32'hDEAD_BEEF);
    chk("coll_same_edge_beat4", beat_data[4], 32'hC4);
    run_req(32'h2000, 1'b0, -1, 32'h0, 32'h0, -1);
    chk("coll_new_beat4", beat_data[4], 32'h1234_5678);

    // Reset during beat 3, then re-fetch to show the array survived.
    run_req(32'h1000, 1'b0, -1, 32'h0, 32'h0, 3);
    run_req(32'h1000, 1'b0, -1, 32'h0, 32'h0, -1);
    chk("refetch_beat3", beat_data[3], 32'hA3);
    chk("refetch_beat7", beat_data[7], 32'hA7);

    // Back-to-back: valid held high, second address queued immediately.
    do_reset();
    req_valid = 1'b1; req_addr = 32'h1000;
    chk("b2b_ready", req_ready, 1);
    t0 = cyc;
    tick();
    req_addr = 32'h2040;
    acc = -1; nb = 0;
    for (int i = 0; i < 40; i++) begin
      pre = cyc;
      r = req_ready;
      tick();
      if (rsp_valid) nb++;
      if (r) begin
        acc = pre;
        break;
      end
    end
    req_valid = 1'b0;
    chk("b2b_accept_cycle", acc, t0 + RL + 8);
    chk("b2b_first_beats", nb, 8);
    chk("b2b_wait_no_beat", rsp_valid, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("b2b_valid", rsp_valid, 1);
      chk("b2b_data", rsp_data, model_mem[32'h810 + k]);
      chk("b2b_last", rsp_last, (k == 7));
    end
    tick();
    chk("b2b_done_valid", rsp_valid, 0);
    chk("b2b_done_ready", req_ready, 1);
    chk("b2b_req_count", req_count, 2);
    $display("back-to-back: second accepted in cycle %0d (first request cycle %0d)", acc, t0);
    model_count = 2;

    // Randomized requests with random loads, checked against the model.
    for (int n = 0; n < 40; n++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        if ($urandom_range(0, 2) == 0) rand_load(32'($urandom_range(0, 65535)) & 32'hFFFF_FFE0);
        tick();
        apply_load();
      end
      if ($urandom_range(0, 7) == 0) addr = $urandom | 32'h0001_0000;
      else                           addr = 32'($urandom_range(0, 65535));
      run_req(addr, 1'b1, -1, 32'h0, 32'h0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_line_responder.md
Name: imem_line_responder

Overview:
- Memory-side responder for the L1 instruction-cache refill interface; it sits between the icache memory port and the on-chip instruction SRAM.
- Accepts one line-fill request through a valid/ready handshake, waits a programmable latency, then streams the whole cache line word by word with no backpressure.
- Also provides a word-write load port so the testbench or boot loader can initialise the program image.

Parameters:
- MEM_BYTES, 65536, backing store size in bytes; power of 2; DEPTH = MEM_BYTES/4 words.
- LINE_SIZE, 32, line size in bytes; power of 2, ≥ 4; WORDS_PER_LINE = LINE_SIZE/4.
- READ_LATENCY, 2, cycles from request acceptance to the first data beat; must be ≥ 1.
- ADDR_WIDTH, 32, request address width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- mem_req_valid_i  in  1  refill request valid.
- mem_req_addr_i  in  ADDR_WIDTH  refill byte address.
- mem_req_ready_o  out  1  responder can accept a request.
- mem_rsp_valid_o  out  1  data beat valid.
- mem_rsp_data_o  out  32  data beat.
- mem_rsp_last_o  out  1  final beat of the line.
- mem_rsp_err_o  out  1  beat belongs to an out-of-range request.
- load_we_i  in  1  load-port word write enable.
- load_addr_i  in  ADDR_WIDTH  load-port byte address; bits [1:0] ignored.
- load_data_i  in  32  load-port write data.
- busy_o  out  1  a request is in flight.
- req_count_o  out  32  number of accepted requests.

Behaviour:
- Clock and reset: one clock domain (clk_i); rst_ni is asynchronous and active-low.
- Reset values:
  - State is IDLE.
  - mem_req_ready_o = 1.
  - mem_rsp_valid_o, mem_rsp_last_o, mem_rsp_err_o and busy_o = 0.
  - mem_rsp_data_o = 0.
  - req_count_o = 0.
  - Array contents are NOT reset.
- FSM states: IDLE, WAIT, BURST.
- IDLE:
  - mem_req_ready_o = 1.
  - On mem_req_valid_i & ready at edge T, latch base = addr with the low log2(LINE_SIZE) bits cleared.
  - Latch err = (base ≥ MEM_BYTES), comparing the full ADDR_WIDTH.
  - Load the latency counter with READ_LATENCY-1, increment req_count_o, and go to WAIT (or straight to BURST if READ_LATENCY = 1).
- WAIT:
  - Counter decrements each cycle; at 0, go to BURST.
  - Beat 0 is valid in the cycle that starts READ_LATENCY cycles after edge T.
- BURST:
  - One beat per cycle, beat index k = 0..WORDS_PER_LINE-1.
  - mem_rsp_data_o = mem[base/4 + k], or 0 when err is set.
  - mem_rsp_err_o = err on every beat.
  - mem_rsp_last_o = 1 only on beat WORDS_PER_LINE-1.
  - After the last beat, return to IDLE; ready is high in the following cycle.
- Outputs outside BURST:
  - mem_rsp_valid_o, mem_rsp_last_o and mem_rsp_err_o are 0 and data is 0.
  - Responses are registered outputs: array read and output register in the same cycle pipeline, so beat k data appears in beat k's cycle.
- busy_o = state != IDLE. mem_req_ready_o = state == IDLE.
- The response channel has no ready signal; the consumer must sink every beat.
- A request presented while not ready is held by the initiator; the responder neither drops nor queues it.
- Load port:
  - Writes when load_we_i = 1 in any state, at the clock edge.
  - Ignored when load_addr_i ≥ MEM_BYTES.
  - A load to the word read by beat k in the same cycle: the beat returns the OLD value. The new value is visible from the next cycle.
- Wrap and arithmetic:
  - Beat index is a log2(WORDS_PER_LINE)-bit counter; it does not increment beyond the last beat.
  - req_count_o wraps from 0xFFFFFFFF to 0.
- Reset mid-burst: immediate return to the reset values with no further beats. The array keeps its contents.
- Back-to-back requests: minimum spacing is READ_LATENCY + WORDS_PER_LINE cycles between acceptances.

Test Plan:
- Basic fill: load words 0x1000..0x101C with 0xA0..0xA7; request addr 0x1004 at cycle 0 with default parameters.
  - ready drops in cycle 1.
  - Beats in cycles 2..9 carry 0xA0..0xA7.
  - last = 1 only in cycle 9; ready = 1 in cycle 10; req_count_o = 1.
- Latency sweep: READ_LATENCY = 1 and = 5.
  - First beat at T+1 and T+5 respectively.
  - Exactly 8 beats each.
- Out of range: request 0x0001_0000 with MEM_BYTES = 65536.
  - 8 beats, data 0, err = 1 on all beats, last on beat 7.
  - A later in-range request has err = 0.
- Load collision: during the burst of line 0x2000, write 0xDEADBEEF to 0x2008 in the same cycle as beat 2.
  - Beat 2 returns the old value.
  - A re-request of the line returns 0xDEADBEEF on beat 2.
- Reset mid-burst: assert rst_ni low during beat 3.
  - valid, last, err and busy go to 0 immediately; ready = 1 after reset release.
  - Array data is retained, checked by re-fetching the line.
- Back-pressure/ordering: hold valid high with two distinct addresses queued by the bench.
  - The second request is accepted exactly at T+READ_LATENCY+8.
  - No beats overlap; req_count_o = 2.
